// File: rtl/multicycle_divider.sv
// Multicycle restoring divider: one quotient bit per clock on operand magnitudes,
// sign correction and exception handling applied in a final FINISH cycle.
module multicycle_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic             ctrl_signed,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] divisor_r;
    logic             neg_quot_r;
    logic             neg_rem_r;
    logic             exc_r;

    logic             start_s;
    logic             last_iter_s;
    logic             sign_a_s;
    logic             sign_b_s;
    logic             exc_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH:0]   diff_s;
    logic             fits_s;

    // Two's-complement negate when requested; the most-negative value maps to
    // its own bit pattern, which is exactly its WIDTH-bit unsigned magnitude.
    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                      input logic             neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    assign busy        = (state_r != IDLE);
    assign last_iter_s = (count_r == CNT_W'(WIDTH - 1));

    // Next-state decode and start qualification.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (ctrl_DIV) begin
                    start_s      = 1'b1;
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (last_iter_s) begin
                    state_next_s = FINISH;
                end else begin
                    state_next_s = CALC;
                end
            end
            FINISH:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Operand classification and one restoring-division step.
    always_comb begin
        sign_a_s = ctrl_signed & data_operandA[WIDTH-1];
        sign_b_s = ctrl_signed & data_operandB[WIDTH-1];
        exc_s    = (data_operandB == {WIDTH{1'b0}}) |
                   (ctrl_signed &
                    (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &
                    (data_operandB == {WIDTH{1'b1}}));
        trial_s  = {rem_r, quot_r[WIDTH-1]};
        diff_s   = trial_s - {1'b0, divisor_r};
        // No borrow out of the subtraction means the divisor fits.
        fits_s   = ~diff_s[WIDTH];
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r        <= {CNT_W{1'b0}};
            quot_r         <= {WIDTH{1'b0}};
            rem_r          <= {WIDTH{1'b0}};
            divisor_r      <= {WIDTH{1'b0}};
            neg_quot_r     <= 1'b0;
            neg_rem_r      <= 1'b0;
            exc_r          <= 1'b0;
            data_result    <= {WIDTH{1'b0}};
            data_remainder <= {WIDTH{1'b0}};
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        quot_r     <= cond_negate(data_operandA, sign_a_s);
                        divisor_r  <= cond_negate(data_operandB, sign_b_s);
                        rem_r      <= {WIDTH{1'b0}};
                        count_r    <= {CNT_W{1'b0}};
                        neg_quot_r <= sign_a_s ^ sign_b_s;
                        neg_rem_r  <= sign_a_s;
                        exc_r      <= exc_s;
                    end
                end
                CALC: begin
                    rem_r   <= fits_s ? diff_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
                    quot_r  <= {quot_r[WIDTH-2:0], fits_s};
                    count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                FINISH: begin
                    data_resultRDY <= 1'b1;
                    if (exc_r) begin
                        data_result    <= {WIDTH{1'b0}};
                        data_remainder <= {WIDTH{1'b0}};
                        data_exception <= 1'b1;
                    end else begin
                        data_result    <= cond_negate(quot_r, neg_quot_r);
                        data_remainder <= cond_negate(rem_r, neg_rem_r);
                        data_exception <= 1'b0;
                    end
                end
                default: begin
                    data_resultRDY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/multicycle_divider.md
MULTICYCLE_DIVIDER -- requirements
Module: multicycle_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal range 4..64).
REQ-002 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ctrl_DIV  input  1  start request, sampled on clock edges.
REQ-005 SHALL have port ctrl_signed  input  1  1 = two's-complement division, 0 = unsigned; sampled with ctrl_DIV.
REQ-006 SHALL have port data_operandA  input  WIDTH  dividend.
REQ-007 SHALL have port data_operandB  input  WIDTH  divisor.
REQ-008 SHALL have port data_result  output  WIDTH  quotient, registered.
REQ-009 SHALL have port data_remainder  output  WIDTH  remainder, registered.
REQ-010 SHALL have port data_resultRDY  output  1  one-cycle completion pulse, registered.
REQ-011 SHALL have port data_exception  output  1  divide-by-zero or signed overflow flag, registered.
REQ-012 SHALL have port busy  output  1  high while an operation is in progress.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FINISH; one quotient bit per clock in CALC (restoring or non-restoring, designer's choice).
REQ-014 SHALL, on edge N with state IDLE and ctrl_DIV=1, latch operands, ctrl_signed, operand signs and magnitudes, clear iteration counter, enter CALC.
REQ-015 SHALL perform iterations on edges N+1..N+WIDTH and enter FINISH on edge N+WIDTH.
REQ-016 SHALL, on edge N+WIDTH+1, apply sign correction, update data_result, data_remainder, data_exception, set data_resultRDY=1, return to IDLE; latency fixed at WIDTH+1 cycles for every operand pair including exceptions.
REQ-017 SHALL deassert data_resultRDY on the next edge; outputs hold their values until the next completion or reset.
REQ-018 SHALL drive busy=1 exactly in CALC and FINISH.
REQ-019 SHALL ignore ctrl_DIV while busy=1; operand and ctrl_signed changes after the start edge SHALL NOT affect the running operation.
REQ-020 SHALL accept ctrl_DIV in the cycle data_resultRDY is high (back-to-back start, zero idle cycles).
REQ-021 SHALL use truncating division in signed mode: quotient rounds toward zero, remainder takes dividend's sign, A = Q*B + R.
REQ-022 SHALL treat the most-negative dividend correctly via WIDTH-bit unsigned magnitude (no WIDTH+1 intermediate overflow).
REQ-023 SHALL, when divisor is zero (either mode), set data_exception=1, data_result=0, data_remainder=0.
REQ-024 SHALL, in signed mode with dividend = most-negative and divisor = -1, set data_exception=1, data_result=0, data_remainder=0.
REQ-025 SHALL set data_exception=0 for all other operand pairs.

Reset
REQ-026 SHALL, on any edge with reset=1, force state IDLE, counter 0, data_result=0, data_remainder=0, data_resultRDY=0, data_exception=0, busy=0.
REQ-027 SHALL give reset priority over ctrl_DIV and over completion; reset mid-operation aborts with no data_resultRDY pulse.
REQ-028 SHALL accept a new ctrl_DIV on the first edge after reset deasserts.

Verification (WIDTH=32)
REQ-029 SHALL cover: signed, A=-2147483648, B=-2147483648, start edge N -> data_resultRDY high after edge N+33 only, result 1, remainder 0, exception 0.
REQ-030 SHALL cover: signed 7/-2 -> result -3, remainder 1; signed -7/2 -> result -3, remainder -1; unsigned 0xFFFFFFFF/0x10 -> 0x0FFFFFFF, remainder 0xF.
REQ-031 SHALL cover: 12345/0 both modes -> exception 1, result 0, remainder 0, same 33-cycle latency.
REQ-032 SHALL cover: signed 0x80000000/0xFFFFFFFF -> exception 1, result 0; unsigned same operands -> exception 0, result 0, remainder 0x80000000.
REQ-033 SHALL cover: reset asserted on iteration 10 -> busy 0 and all outputs 0 next cycle, no ready pulse; ctrl_DIV pulsed while busy -> ignored, single ready pulse for the original operation.
REQ-034 SHALL cover: ctrl_DIV reasserted in the data_resultRDY cycle with new operands 100/7 -> second ready exactly 33 cycles later, result 14, remainder 2; first results held until then.
